// File: rtl/afg_trig_pkg.sv
// afg_trig_pkg: shared encodings for the AFG trigger sequencer.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package afg_trig_pkg;

  // Sequencer states, kept as fixed 2-bit codes so netlists and older tools see stable values.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // Trigger source select codes.
  localparam logic [1:0] SRC_FREE = 2'd0;
  localparam logic [1:0] SRC_MAN  = 2'd1;
  localparam logic [1:0] SRC_EXT  = 2'd2;
  localparam logic [1:0] SRC_TMR  = 2'd3;

  // A burst is in progress (playing or cooling down) and new triggers are refused.
  function automatic logic st_is_busy(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_HOLDOFF);
  endfunction

endpackage

// File: rtl/afg_trig_edge_detect.sv
// afg_trig_edge_detect: 2-flop synchronizer plus rising-edge pulse for one asynchronous trigger pin.
// Latency: one-cycle pulse appears 2-3 clocks after the pin rises (combinational off the sync/prev flops).
// Backpressure: none; every synchronized rising edge yields exactly one pulse.
module afg_trig_edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic din,
  output logic rise
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the pin through two sync stages and keep one older sample for edge detection.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and history registers, cleared by async reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/afg_trigger_sequencer.sv
// afg_trigger_sequencer: trigger select/edge detect, burst playback control and hold-off re-arm.
// Latency: pin edge to Wave_Start <= 3 clocks; free-run/timer trigger to Wave_Start 1 clock.
// Backpressure: triggers seen while busy are dropped and flagged on Trig_Miss (optional Miss_Cnt via TRIG_MISS_CNT_EN).
module afg_trigger_sequencer
  import afg_trig_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMR_W   = 24,
  parameter int HOLDOFF = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             EN,
  input  logic             Man_Trig_in,
  input  logic             Ext_Trig_in,
  input  logic [1:0]       Src_Sel,
  input  logic [CNT_W-1:0] Burst_Count,
  input  logic [TMR_W-1:0] Timer_Period,
  input  logic             Wave_Done,
  output logic             Wave_Start,
  output logic             Play,
  output logic             Busy,
  output logic             Trig_Miss
`ifdef TRIG_MISS_CNT_EN
  ,
  output logic [7:0]       Miss_Cnt
`endif
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             wave_start_q, wave_start_d;
  logic             trig_miss_q, trig_miss_d;

  logic             man_rise;
  logic             ext_rise;
  logic             tmr_tick;
  logic             trig_evt;
  logic [CNT_W-1:0] done_inc;

  afg_trig_edge_detect u_man_edge (
    .Clock (Clock),
    .Reset (Reset),
    .din   (Man_Trig_in),
    .rise  (man_rise)
  );

  afg_trig_edge_detect u_ext_edge (
    .Clock (Clock),
    .Reset (Reset),
    .din   (Ext_Trig_in),
    .rise  (ext_rise)
  );

  // Internal timer: runs only while enabled with the timer selected, ticks and wraps at Timer_Period.
  always_comb begin
    tmr_tick = 1'b0;
    tmr_d    = '0;
    if (EN && (Src_Sel == SRC_TMR)) begin
      if (tmr_q == Timer_Period) begin
        tmr_tick = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  // Pick the edge-type event of the selected source; free-run is a level, not an event.
  always_comb begin
    trig_evt = 1'b0;
    case (Src_Sel)
      SRC_MAN: trig_evt = man_rise;
      SRC_EXT: trig_evt = ext_rise;
      SRC_TMR: trig_evt = tmr_tick;
      default: trig_evt = 1'b0;
    endcase
  end

  // Sequencer FSM: arm, start a burst, count completed waveforms, hold off, re-arm.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    done_d       = done_q;
    hold_d       = hold_q;
    wave_start_d = 1'b0;
    trig_miss_d  = 1'b0;
    done_inc     = done_q + 1'b1;
    if (!EN) begin
      state_d = ST_IDLE;
      burst_d = '0;
      done_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig_evt || (Src_Sel == SRC_FREE)) begin
            state_d      = ST_RUN;
            burst_d      = Burst_Count;
            done_d       = '0;
            wave_start_d = 1'b1;
          end
        end
        ST_RUN: begin
          trig_miss_d = trig_evt;
          if (Wave_Done) begin
            // In infinite mode (burst_q == 0) the count just wraps and is never compared.
            done_d = done_inc;
            if ((burst_q != '0) && (done_inc == burst_q)) begin
              state_d = ST_HOLDOFF;
              hold_d  = '0;
            end
          end
        end
        ST_HOLDOFF: begin
          trig_miss_d = trig_evt;
          if (hold_q == HOLD_LAST) begin
            state_d = ST_ARMED;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer and timer registers; async reset returns everything to IDLE with outputs low.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      burst_q      <= '0;
      done_q       <= '0;
      hold_q       <= '0;
      tmr_q        <= '0;
      wave_start_q <= 1'b0;
      trig_miss_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      done_q       <= done_d;
      hold_q       <= hold_d;
      tmr_q        <= tmr_d;
      wave_start_q <= wave_start_d;
      trig_miss_q  <= trig_miss_d;
    end
  end

  assign Wave_Start = wave_start_q;
  assign Play       = (state_q == ST_RUN);
  assign Busy       = st_is_busy(state_q);
  assign Trig_Miss  = trig_miss_q;

`ifdef TRIG_MISS_CNT_EN
  logic [7:0] miss_cnt_q, miss_cnt_d;

  // Saturating count of dropped triggers, cleared whenever the sequencer is disabled.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (!EN) begin
      miss_cnt_d = '0;
    end else if (trig_miss_q && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  // Miss counter register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign Miss_Cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_afg_trigger_sequencer.sv
// tb_afg_trigger_sequencer: randomized and directed stimulus against a behavioural burst model.
// Latency: model predicts outputs cycle-exactly; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_afg_trigger_sequencer;

  localparam int CNT_W   = 16;
  localparam int TMR_W   = 24;
  localparam int HOLDOFF = 4;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             EN = 1'b0;
  logic             Man_Trig_in = 1'b0;
  logic             Ext_Trig_in = 1'b0;
  logic [1:0]       Src_Sel = 2'd0;
  logic [CNT_W-1:0] Burst_Count = '0;
  logic [TMR_W-1:0] Timer_Period = '0;
  logic             Wave_Done = 1'b0;
  logic             Wave_Start;
  logic             Play;
  logic             Busy;
  logic             Trig_Miss;
`ifdef TRIG_MISS_CNT_EN
  logic [7:0]       Miss_Cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  afg_trigger_sequencer #(
    .CNT_W   (CNT_W),
    .TMR_W   (TMR_W),
    .HOLDOFF (HOLDOFF)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .EN           (EN),
    .Man_Trig_in  (Man_Trig_in),
    .Ext_Trig_in  (Ext_Trig_in),
    .Src_Sel      (Src_Sel),
    .Burst_Count  (Burst_Count),
    .Timer_Period (Timer_Period),
    .Wave_Done    (Wave_Done),
    .Wave_Start   (Wave_Start),
    .Play         (Play),
    .Busy         (Busy),
    .Trig_Miss    (Trig_Miss)
`ifdef TRIG_MISS_CNT_EN
    ,
    .Miss_Cnt     (Miss_Cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Burst bookkeeping in plain terms: enabled flag, playing flag, waveforms left,
  // cool-down cycles left. Pin history holds the pin level seen at recent rising edges.
  bit m_on, m_play, m_inf;
  int m_left, m_cool, m_age;
  bit e_start, e_miss;
  int e_misscnt;
  bit mh [3];
  bit eh [3];
  bit man_evt, ext_evt, tick, evt;

  always @(posedge Clock) begin
    if (Reset) begin
      m_on = 0; m_play = 0; m_inf = 0; m_left = 0; m_cool = 0; m_age = 0;
      e_start = 0; e_miss = 0; e_misscnt = 0;
      for (int i = 0; i < 3; i++) begin mh[i] = 0; eh[i] = 0; end
    end else begin
      // A pin edge becomes usable two edges after it is first sampled.
      man_evt = mh[1] && !mh[2];
      ext_evt = eh[1] && !eh[2];
      tick = EN && (Src_Sel == 2'd3) &&
             ((m_age % (int'(Timer_Period) + 1)) == int'(Timer_Period));
      m_age = (EN && (Src_Sel == 2'd3)) ? m_age + 1 : 0;
      case (Src_Sel)
        2'd1: evt = man_evt;
        2'd2: evt = ext_evt;
        2'd3: evt = tick;
        default: evt = 0;
      endcase
      if (!EN) e_misscnt = 0;
      else if (e_miss && e_misscnt < 255) e_misscnt = e_misscnt + 1;
      e_start = 0;
      e_miss  = 0;
      if (!EN) begin
        m_on = 0; m_play = 0; m_cool = 0;
      end else if (!m_on) begin
        m_on = 1;
      end else if (m_play) begin
        e_miss = evt;
        if (Wave_Done && !m_inf) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_play = 0; m_cool = HOLDOFF; end
        end
      end else if (m_cool > 0) begin
        e_miss = evt;
        m_cool = m_cool - 1;
      end else if (evt || (Src_Sel == 2'd0)) begin
        m_play = 1; m_left = int'(Burst_Count); m_inf = (Burst_Count == '0); e_start = 1;
      end
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = Man_Trig_in;
      eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = Ext_Trig_in;
    end
  end

  task automatic cycle_check();
    @(negedge Clock);
    chk("wave_start", Wave_Start, e_start);
    chk("play", Play, m_play);
    chk("busy", Busy, (m_play || (m_cool > 0)));
    chk("trig_miss", Trig_Miss, e_miss);
`ifdef TRIG_MISS_CNT_EN
    chk("miss_cnt", Miss_Cnt, e_misscnt);
`endif
  endtask

  task automatic quiesce();
    EN = 1'b0;
    Wave_Done = 1'b0;
    repeat (2) cycle_check();
  endtask

  task automatic run_seg(input int src, input int burst, input int period, input int ncyc,
                         input int done_pct, input int pin_pct, input bit jitter);
    quiesce();
    Src_Sel = 2'(src);
    Burst_Count = CNT_W'(burst);
    Timer_Period = TMR_W'(period);
    EN = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      cycle_check();
      Wave_Done = ($urandom_range(99) < done_pct);
      if ($urandom_range(99) < pin_pct) Man_Trig_in = ~Man_Trig_in;
      if ($urandom_range(99) < pin_pct) Ext_Trig_in = ~Ext_Trig_in;
      if (jitter && ($urandom_range(19) == 0)) Burst_Count = CNT_W'($urandom_range(5));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int lat, hold, misses;
    // Reset state.
    repeat (2) cycle_check();
    chk("rst_wave_start", Wave_Start, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b0;

    // Manual trigger, 3-waveform burst, then hold-off length.
    Src_Sel = 2'd1; Burst_Count = 16'd3; EN = 1'b1;
    repeat (4) cycle_check();
    Man_Trig_in = 1'b1;
    lat = 0;
    do begin cycle_check(); lat++; end while (!Wave_Start && lat < 10);
    chk("man_to_start", lat, 3);
    for (int k = 0; k < 2; k++) begin
      Wave_Done = 1'b1; cycle_check(); Wave_Done = 1'b0; cycle_check(); cycle_check();
    end
    chk("man_play_mid", Play, 1);
    Wave_Done = 1'b1;
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      cycle_check();
      Wave_Done = 1'b0;
      if (Busy && !Play) hold++;
    end
    chk("holdoff_cycles", hold, HOLDOFF);

    // External trigger with a second edge during the burst.
    quiesce();
    Man_Trig_in = 1'b0; Ext_Trig_in = 1'b0; Src_Sel = 2'd2; Burst_Count = 16'd4; EN = 1'b1;
    repeat (4) cycle_check();
    Ext_Trig_in = 1'b1;
    lat = 0;
    do begin cycle_check(); lat++; end while (!Wave_Start && lat < 10);
    chk("ext_to_start", lat, 3);
    Ext_Trig_in = 1'b0;
    repeat (2) cycle_check();
    Ext_Trig_in = 1'b1;
    misses = 0;
    for (int i = 0; i < 8; i++) begin cycle_check(); if (Trig_Miss) misses++; end
    chk("ext_miss_pulses", misses, 1);
`ifdef TRIG_MISS_CNT_EN
    chk("ext_miss_cnt", Miss_Cnt, 1);
`endif
    for (int k = 0; k < 4; k++) begin
      Wave_Done = 1'b1; cycle_check(); Wave_Done = 1'b0; cycle_check();
    end
    chk("ext_burst_end_play", Play, 0);
    chk("ext_burst_end_busy", Busy, 1);

    // Randomized segments covering each source and the boundary cases.
    run_seg(2, 3, 0, 200, 15, 8, 0);
    run_seg(3, 1, 9, 200, 30, 0, 0);
    run_seg(0, 0, 0, 260, 50, 0, 0);
    run_seg(0, 2, 0, 200, 20, 0, 1);

    // Asynchronous reset in the middle of an infinite free-run burst.
    run_seg(0, 0, 0, 10, 30, 0, 0);
    chk("pre_rst_play", Play, 1);
    #2 Reset = 1'b1;
    #1;
    chk("async_rst_play", Play, 0);
    chk("async_rst_busy", Busy, 0);
    chk("async_rst_wave_start", Wave_Start, 0);
    cycle_check();
    cycle_check();
    Reset = 1'b0;
    repeat (6) cycle_check();

    for (int s = 0; s < 10; s++) begin
      run_seg(int'($urandom_range(3)), int'($urandom_range(4)), int'($urandom_range(12)),
              150, int'($urandom_range(40, 10)), int'($urandom_range(15, 5)), 1'b1);
    end
    quiesce();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
